viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with generators 101/111. It sits directly downstream of the encoder and its serial-to-pair deframer. It consumes one received symbol pair per accepted `clk_div2` cycle and emits one decoded data bit per pair after a fixed traceback latency. Survivor paths use register exchange, so latency is deterministic and there is no traceback RAM.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/viterbi_acs.sv | 28 ++
 rtl/viterbi_decoder.sv | 103 ++++++++++
 tb/tb_viterbi_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=3 (101/111) convolutional code.
// Used by both the Viterbi decoder and the encoder golden model.
package conv_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 4;
    localparam int PM_W       = 4;
    localparam logic [PM_W-1:0] PM_MAX = 4'd15;

    localparam logic [K-1:0] G_A = 3'b101;  // drives sym[1]
    localparam logic [K-1:0] G_B = 3'b111;  // drives sym[0]

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [1:0]      state_t;
    typedef logic [1:0]      bm_t;

    // Encoder output for input bit b leaving state {x[t-1], x[t-2]}.
    function automatic logic [1:0] exp_sym(input state_t state, input logic b);
        logic [K-1:0] taps;
        taps = {b, state};
        return {^(taps & G_A), ^(taps & G_B)};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: saturating adds, pick the
// smaller candidate, ties resolved toward the predecessor with LSB 0.
module viterbi_acs
    import conv_pkg::*;
(
    input  pm_t  pm_a,
    input  pm_t  pm_b,
    input  bm_t  bm_a,
    input  bm_t  bm_b,
    output pm_t  pm_out,
    output logic dec
);

    logic [PM_W:0] sum_a;
    logic [PM_W:0] sum_b;
    pm_t           cand_a;
    pm_t           cand_b;

    assign sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
    assign sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
    assign cand_a = (sum_a > {1'b0, PM_MAX}) ? PM_MAX : sum_a[PM_W-1:0];
    assign cand_b = (sum_b > {1'b0, PM_MAX}) ? PM_MAX : sum_b[PM_W-1:0];

    // Strict compare so a tie keeps predecessor a.
    assign dec    = (cand_b < cand_a);
    assign pm_out = dec ? cand_b : cand_a;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the K=3 101/111 code.
// One symbol pair per accepted clk_div2 edge, fixed TB_DEPTH-symbol latency.
module viterbi_decoder
    import conv_pkg::*;
#(
    parameter int TB_DEPTH = 15
) (
    input  logic       clk_div2,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] sym,
    input  logic       sym_valid,
    output logic       dec,
    output logic       dec_valid
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(TB_DEPTH);

    pm_t                 pm_q      [NUM_STATES];
    pm_t                 pm_next   [NUM_STATES];
    pm_t                 acs_pm    [NUM_STATES];
    logic                acs_dec   [NUM_STATES];
    logic [TB_DEPTH-1:0] path_q    [NUM_STATES];
    logic [TB_DEPTH-1:0] path_next [NUM_STATES];
    bm_t                 bm        [NUM_STATES][2];
    logic [CNT_W-1:0]    fill_q;
    pm_t                 pm_min;
    state_t              best;
    pm_t                 best_pm;

    // NOTE: every always_comb output gets a default before any conditional
    // update so no path leaves it unassigned and infers a latch.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int b = 0; b < 2; b++) begin
                logic [1:0] diff;
                diff     = sym ^ exp_sym(state_t'(s), 1'(b));
                bm[s][b] = {1'b0, diff[1]} + {1'b0, diff[0]};
            end
        end
    end

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam state_t N = state_t'(n);
        localparam state_t PRED_A = {N[0], 1'b0};
        localparam state_t PRED_B = {N[0], 1'b1};

        viterbi_acs u_acs (
            .pm_a   (pm_q[PRED_A]),
            .pm_b   (pm_q[PRED_B]),
            .bm_a   (bm[PRED_A][N[1]]),
            .bm_b   (bm[PRED_B][N[1]]),
            .pm_out (acs_pm[n]),
            .dec    (acs_dec[n])
        );

        assign path_next[n] = {path_q[{N[0], acs_dec[n]}][TB_DEPTH-2:0], N[1]};
    end

    always_comb begin
        pm_min = acs_pm[0];
        for (int i = 1; i < NUM_STATES; i++)
            if (acs_pm[i] < pm_min) pm_min = acs_pm[i];
        for (int i = 0; i < NUM_STATES; i++)
            pm_next[i] = acs_pm[i] - pm_min;
    end

    // Best state is taken from the metrics before this edge's update.
    always_comb begin
        best    = '0;
        best_pm = pm_q[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_q[i] < best_pm) begin
                best    = state_t'(i);
                best_pm = pm_q[i];
            end
        end
    end

    // NOTE: the survivor paths are flops rather than a RAM, so they are
    // cleared on reset like any other state; a restart must not leak bits.
    always_ff @(posedge clk_div2) begin
        if (!rst_n || start) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
                path_q[i] <= '0;
            end
            fill_q    <= '0;
            dec       <= 1'b0;
            dec_valid <= 1'b0;
        end else if (sym_valid) begin
            pm_q      <= pm_next;
            path_q    <= path_next;
            if (fill_q != FILL_FULL) fill_q <= fill_q + CNT_W'(1);
            dec       <= path_q[best][TB_DEPTH-1];
            dec_valid <= (fill_q == FILL_FULL);
        end else begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder at TB_DEPTH=15 and TB_DEPTH=5 in parallel;
// a reference encoder feeds the DUTs and a queue scoreboard predicts outputs.
module tb_viterbi_decoder;

    logic       clk_div2 = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] sym;
    logic       sym_valid;
    logic       dec, dec_valid;
    logic       dec5, dec_valid5;

    int n_checks = 0;
    int n_fails  = 0;

    bit         q15[$];
    bit         q5[$];
    int         fill15;
    int         fill5;
    bit         check_dec5;
    logic [1:0] enc_state;

    always #5 clk_div2 = ~clk_div2;

    viterbi_decoder #(.TB_DEPTH(15)) dut (
        .clk_div2  (clk_div2),
        .rst_n     (rst_n),
        .start     (start),
        .sym       (sym),
        .sym_valid (sym_valid),
        .dec       (dec),
        .dec_valid (dec_valid)
    );

    viterbi_decoder #(.TB_DEPTH(5)) dut5 (
        .clk_div2  (clk_div2),
        .rst_n     (rst_n),
        .start     (start),
        .sym       (sym),
        .sym_valid (sym_valid),
        .dec       (dec5),
        .dec_valid (dec_valid5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: sym[1] = b^x[t-2], sym[0] = b^x[t-1]^x[t-2].
    function automatic logic [1:0] encode(input logic [1:0] s, input logic b);
        return {b ^ s[0], b ^ s[1] ^ s[0]};
    endfunction

    task automatic step(input bit v, input logic [1:0] s, input bit x,
                        input bit st = 1'b0, input bit rn = 1'b1);
        bit e;
        sym_valid = v;
        sym       = s;
        start     = st;
        rst_n     = rn;
        @(posedge clk_div2);
        #1;
        if (!rn || st) begin
            q15.delete(); q5.delete();
            fill15 = 0;   fill5 = 0;
            check("rst_dv15", dec_valid, 0);
            check("rst_dec15", dec, 0);
            check("rst_dv5", dec_valid5, 0);
            check("rst_dec5", dec5, 0);
        end else if (v) begin
            check("dv15", dec_valid, (fill15 == 15));
            if (fill15 == 15) begin
                e = q15.pop_front();
                check("dec15", dec, e);
            end
            q15.push_back(x);
            if (fill15 < 15) fill15++;

            check("dv5", dec_valid5, (fill5 == 5));
            if (fill5 == 5) begin
                e = q5.pop_front();
                if (check_dec5) check("dec5", dec5, e);
            end
            q5.push_back(x);
            if (fill5 < 5) fill5++;
        end else begin
            check("idle_dv15", dec_valid, 0);
            check("idle_dv5", dec_valid5, 0);
        end
    endtask

    task automatic send(input bit x, input logic [1:0] flip = 2'b00);
        logic [1:0] s;
        s         = encode(enc_state, x) ^ flip;
        enc_state = {x, enc_state[1]};
        step(1'b1, s, x);
    endtask

    task automatic restart();
        enc_state = 2'b00;
        step(1'b1, 2'b11, 1'b0, 1'b1, 1'b1);
    endtask

    bit pattern [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        enc_state  = 2'b00;
        check_dec5 = 1'b1;
        fill15     = 0;
        fill5      = 0;

        // Reset with a junk valid pair presented: it must be discarded.
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check("rst_pm0", dut.pm_q[0], 0);
        check("rst_pm1", dut.pm_q[1], 15);
        check("rst_pm3", dut.pm_q[3], 15);
        check("rst_fill", dut.fill_q, 0);

        // All-zero stream: state 0 metric pinned at zero throughout.
        for (int i = 0; i < 40; i++) begin
            send(1'b0);
            check("zero_pm0_15", dut.pm_q[0], 0);
            check("zero_pm0_5", dut5.pm_q[0], 0);
        end

        // Known pattern, error-free.
        restart();
        for (int i = 0; i < 27; i++) send(i < 7 ? pattern[i] : 1'b0);

        // Same stream with sym[1] of pair 2 flipped.
        restart();
        check_dec5 = 1'b0;
        for (int i = 0; i < 27; i++)
            send(i < 7 ? pattern[i] : 1'b0, (i == 2) ? 2'b10 : 2'b00);

        // Isolated single errors spaced 8 pairs apart over a longer stream.
        restart();
        for (int i = 0; i < 60; i++)
            send((i < 40) ? 1'($urandom_range(0, 1)) : 1'b0,
                 (i % 8 == 3) ? ((i % 16 == 3) ? 2'b01 : 2'b10) : 2'b00);
        check_dec5 = 1'b1;

        // Valid gaps: idle every third cycle with random garbage on sym.
        restart();
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 27) begin
                if (cyc % 3 == 2) begin
                    step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
                end else begin
                    send(sent < 7 ? pattern[sent] : 1'b0);
                    sent++;
                end
                cyc++;
            end
        end

        // Mid-stream restart after 25 pairs, then replay the pattern.
        restart();
        for (int i = 0; i < 25; i++) send(i < 7 ? pattern[i] : 1'b0);
        restart();
        for (int i = 0; i < 27; i++) send(i < 7 ? pattern[i] : 1'b0);

        // Reset mid-stream just after dec carried x[0]=1.
        restart();
        for (int i = 0; i < 16; i++) send(i < 7 ? pattern[i] : 1'b0);
        check("pre_rst_dec15", dec, 1);
        enc_state = 2'b00;
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        check("post_rst_pm1", dut.pm_q[1], 15);
        for (int i = 0; i < 10; i++) send(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
